// File: rtl/key_tone_if.sv
// key_tone_if: board-side bundle between the key inputs, the speaker pin and
// the tone scheduler.
//   keys      raw key levels, 1 = pressed, asynchronous to clk (board -> dut)
//   mute      1 forces the speaker low                          (board -> dut)
//   speaker   square-wave audio output                          (dut -> board)
//   active    1 while a note is sounding (PLAY)                 (dut -> board)
//   note_idx  note currently selected, 0 when idle              (dut -> board)
interface key_tone_if #(
    parameter int NUM_KEYS = 7
) ();
    logic [NUM_KEYS-1:0] keys;
    logic                mute;
    logic                speaker;
    logic                active;
    logic [2:0]          note_idx;

    modport master (
        output keys, mute,
        input  speaker, active, note_idx
    );

    modport slave (
        input  keys, mute,
        output speaker, active, note_idx
    );
endinterface

// File: rtl/key_tone_scheduler.sv
// key_tone_scheduler: shares one square-wave generator among NUM_KEYS keys
// (index 0 = C4 .. 6 = B4). Keys are synchronised, a single winner is chosen
// with last-pressed priority, a silent gap separates two different notes, and
// the speaker toggles every half-period of the winning note.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    key_tone_if.slave: keys/mute in, speaker/active/note_idx out
module key_tone_scheduler #(
    parameter int NUM_KEYS   = 7,
    parameter int DIV_W      = 18,
    parameter int GAP_CYCLES = 500000,
    parameter int DIV_SHIFT  = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    key_tone_if.slave   bus
);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_GAP, S_PLAY} state_t;

    // Half-period in clk cycles for each note, pre-shifted for simulation.
    function automatic logic [DIV_W-1:0] hp(input logic [2:0] idx);
        logic [31:0] v;
        case (idx)
            3'd0:    v = 32'd191113;
            3'd1:    v = 32'd170262;
            3'd2:    v = 32'd151686;
            3'd3:    v = 32'd143173;
            3'd4:    v = 32'd127553;
            3'd5:    v = 32'd113636;
            default: v = 32'd101238;
        endcase
        return DIV_W'(v >> DIV_SHIFT);
    endfunction

    // Index of the lowest set bit; scanning downward leaves the lowest one.
    function automatic logic [2:0] lowest(input logic [NUM_KEYS-1:0] v);
        logic [2:0] r;
        r = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--)
            if (v[i]) r = 3'(i);
        return r;
    endfunction

    // ---------------- synchroniser and edge detect ----------------
    logic [NUM_KEYS-1:0] sync1_q, ks_q, kp_q;
    logic [NUM_KEYS-1:0] rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            ks_q    <= '0;
            kp_q    <= '0;
        end else begin
            sync1_q <= bus.keys;
            ks_q    <= sync1_q;
            kp_q    <= ks_q;
        end
    end

    assign rise = ks_q & ~kp_q;

    // ---------------- winner selection ----------------
    logic [2:0] win_q, win_d;
    logic       win_vld_q, win_vld_d;

    always_comb begin
        win_d     = '0;
        win_vld_d = 1'b0;
        if (|rise) begin
            // Newest press wins; simultaneous presses resolve to lowest index.
            win_d     = lowest(rise);
            win_vld_d = 1'b1;
        end else if (win_vld_q && ks_q[win_q]) begin
            win_d     = win_q;
            win_vld_d = 1'b1;
        end else if (|ks_q) begin
            // Winner released while others are still down: fall back.
            win_d     = lowest(ks_q);
            win_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q     <= '0;
            win_vld_q <= 1'b0;
        end else begin
            win_q     <= win_d;
            win_vld_q <= win_vld_d;
        end
    end

    // ---------------- FSM, gap timer and tone divider ----------------
    state_t           state_q, state_d;
    logic [2:0]       note_q, note_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             spk_q, spk_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            note_q  <= '0;
            gap_q   <= '0;
            div_q   <= '0;
            spk_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            note_q  <= note_d;
            gap_q   <= gap_d;
            div_q   <= div_d;
            spk_q   <= spk_d;
        end
    end

    always_comb begin
        state_d = state_q;
        note_d  = note_q;
        gap_d   = gap_q;
        div_d   = div_q;
        spk_d   = spk_q;
        case (state_q)
            S_IDLE: begin
                note_d = '0;
                spk_d  = 1'b0;
                // Starting from silence needs no gap.
                if (win_vld_d) begin
                    state_d = S_PLAY;
                    note_d  = win_d;
                    div_d   = hp(win_d) - DIV_ONE;
                end
            end
            S_PLAY: begin
                if (!win_vld_d) begin
                    state_d = S_IDLE;
                    note_d  = '0;
                    spk_d   = 1'b0;
                end else if (win_d != note_q) begin
                    state_d = S_GAP;
                    note_d  = win_d;
                    gap_d   = GAP_LOAD;
                    spk_d   = 1'b0;
                end else if (div_q == '0) begin
                    // Same key (including a re-press) keeps its phase.
                    spk_d = ~spk_q;
                    div_d = hp(note_q) - DIV_ONE;
                end else begin
                    div_d = div_q - DIV_ONE;
                end
            end
            S_GAP: begin
                spk_d = 1'b0;
                if (!win_vld_d) begin
                    state_d = S_IDLE;
                    note_d  = '0;
                end else if (win_d != note_q) begin
                    // Another change during the gap restarts the silence.
                    note_d = win_d;
                    gap_d  = GAP_LOAD;
                end else if (gap_q == '0) begin
                    state_d = S_PLAY;
                    div_d   = hp(note_q) - DIV_ONE;
                end else begin
                    gap_d = gap_q - GAP_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                note_d  = '0;
                spk_d   = 1'b0;
            end
        endcase
    end

    // Mute gates the registered speaker directly so it takes effect at once
    // while the divider keeps counting underneath.
    assign bus.speaker  = spk_q & ~bus.mute;
    assign bus.active   = (state_q == S_PLAY);
    assign bus.note_idx = note_q;

endmodule

// File: tb/tb_key_tone_scheduler.sv
module tb_key_tone_scheduler;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    key_tone_if #(.NUM_KEYS(7)) bus ();

    key_tone_scheduler #(
        .NUM_KEYS  (7),
        .DIV_W     (18),
        .GAP_CYCLES(4),
        .DIV_SHIFT (10)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Cycles until speaker changes level; -1 if it never does within 1000.
    task automatic wait_toggle(output int n);
        logic s0;
        s0 = bus.speaker;
        n  = 0;
        while (bus.speaker === s0 && n < 1000) begin
            tick(1);
            n++;
        end
        if (n >= 1000) n = -1;
    endtask

    task automatic test_reset;
        rst_n    = 1'b0;
        bus.keys = '0;
        bus.mute = 1'b0;
        tick(3);
        checks++;
        if (bus.speaker !== 1'b0 || bus.active !== 1'b0 || bus.note_idx !== 3'd0) begin
            failures++;
            $display("FAIL reset_hold: spk=%b act=%b note=%0d want 0 0 0",
                     bus.speaker, bus.active, bus.note_idx);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            checks++;
            if (bus.speaker !== 1'b0 || bus.active !== 1'b0 || bus.note_idx !== 3'd0) begin
                failures++;
                $display("FAIL reset_idle cyc %0d: spk=%b act=%b note=%0d want 0 0 0",
                         i, bus.speaker, bus.active, bus.note_idx);
            end
        end
    endtask

    task automatic test_single_key;
        int n;
        bus.keys = 7'b0000001;
        tick(2);
        checks++;
        if (bus.active !== 1'b0) begin
            failures++;
            $display("FAIL c_latency_early: active=%b want 0", bus.active);
        end
        tick(1);
        checks++;
        if (bus.active !== 1'b1 || bus.note_idx !== 3'd0 || bus.speaker !== 1'b0) begin
            failures++;
            $display("FAIL c_start: act=%b note=%0d spk=%b want 1 0 0",
                     bus.active, bus.note_idx, bus.speaker);
        end
        wait_toggle(n);
        checks++;
        if (n !== 186 || bus.speaker !== 1'b1) begin
            failures++;
            $display("FAIL c_first_half: cycles=%0d spk=%b want 186 1", n, bus.speaker);
        end
        wait_toggle(n);
        checks++;
        if (n !== 186 || bus.speaker !== 1'b0) begin
            failures++;
            $display("FAIL c_second_half: cycles=%0d spk=%b want 186 0", n, bus.speaker);
        end
    endtask

    // Switch from the playing note to new_keys; expect a 4-cycle silent gap.
    task automatic test_note_change(input string name, input logic [6:0] new_keys,
                                    input logic [2:0] exp_note, input int exp_hp);
        int n;
        bus.keys = new_keys;
        tick(2);
        checks++;
        if (bus.active !== 1'b1) begin
            failures++;
            $display("FAIL %s_pre_gap: active=%b want 1", name, bus.active);
        end
        for (int i = 0; i < 4; i++) begin
            tick(1);
            checks++;
            if (bus.active !== 1'b0 || bus.speaker !== 1'b0 || bus.note_idx !== exp_note) begin
                failures++;
                $display("FAIL %s_gap cyc %0d: act=%b spk=%b note=%0d want 0 0 %0d",
                         name, i, bus.active, bus.speaker, bus.note_idx, exp_note);
            end
        end
        tick(1);
        checks++;
        if (bus.active !== 1'b1 || bus.note_idx !== exp_note) begin
            failures++;
            $display("FAIL %s_play: act=%b note=%0d want 1 %0d",
                     name, bus.active, bus.note_idx, exp_note);
        end
        wait_toggle(n);
        checks++;
        if (n !== exp_hp) begin
            failures++;
            $display("FAIL %s_half1: cycles=%0d want %0d", name, n, exp_hp);
        end
        wait_toggle(n);
        checks++;
        if (n !== exp_hp) begin
            failures++;
            $display("FAIL %s_half2: cycles=%0d want %0d", name, n, exp_hp);
        end
    endtask

    task automatic test_multi_rise;
        int n;
        bus.keys = '0;
        tick(3);
        checks++;
        if (bus.active !== 1'b0 || bus.speaker !== 1'b0 || bus.note_idx !== 3'd0) begin
            failures++;
            $display("FAIL release_idle: act=%b spk=%b note=%0d want 0 0 0",
                     bus.active, bus.speaker, bus.note_idx);
        end
        tick(5);
        bus.keys = 7'b0010100;
        tick(2);
        checks++;
        if (bus.active !== 1'b0) begin
            failures++;
            $display("FAIL multi_early: active=%b want 0", bus.active);
        end
        tick(1);
        checks++;
        if (bus.active !== 1'b1 || bus.note_idx !== 3'd2) begin
            failures++;
            $display("FAIL multi_winner: act=%b note=%0d want 1 2", bus.active, bus.note_idx);
        end
        wait_toggle(n);
        checks++;
        if (n !== 148) begin
            failures++;
            $display("FAIL multi_half: cycles=%0d want 148", n);
        end
        bus.keys = '0;
        tick(3);
        checks++;
        if (bus.active !== 1'b0 || bus.speaker !== 1'b0 || bus.note_idx !== 3'd0) begin
            failures++;
            $display("FAIL multi_release: act=%b spk=%b note=%0d want 0 0 0",
                     bus.active, bus.speaker, bus.note_idx);
        end
    endtask

    task automatic test_mute_reset;
        int n;
        bus.keys = 7'b0010000;
        tick(3);
        checks++;
        if (bus.active !== 1'b1 || bus.note_idx !== 3'd4) begin
            failures++;
            $display("FAIL g_start: act=%b note=%0d want 1 4", bus.active, bus.note_idx);
        end
        wait_toggle(n);
        checks++;
        if (n !== 124 || bus.speaker !== 1'b1) begin
            failures++;
            $display("FAIL g_half: cycles=%0d spk=%b want 124 1", n, bus.speaker);
        end
        bus.mute = 1'b1;
        #1;
        checks++;
        if (bus.speaker !== 1'b0) begin
            failures++;
            $display("FAIL mute_immediate: spk=%b want 0", bus.speaker);
        end
        for (int i = 0; i < 10; i++) begin
            tick(1);
            checks++;
            if (bus.speaker !== 1'b0 || bus.active !== 1'b1) begin
                failures++;
                $display("FAIL mute_hold cyc %0d: spk=%b act=%b want 0 1",
                         i, bus.speaker, bus.active);
            end
        end
        bus.mute = 1'b0;
        #1;
        checks++;
        if (bus.speaker !== 1'b1) begin
            failures++;
            $display("FAIL unmute: spk=%b want 1", bus.speaker);
        end
        // Divider kept running under mute: 10 of the 124 cycles already used.
        wait_toggle(n);
        checks++;
        if (n !== 114) begin
            failures++;
            $display("FAIL mute_phase: cycles=%0d want 114", n);
        end
        wait_toggle(n);
        checks++;
        if (n !== 124 || bus.speaker !== 1'b1) begin
            failures++;
            $display("FAIL g_half_again: cycles=%0d spk=%b want 124 1", n, bus.speaker);
        end
        tick(50);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.speaker !== 1'b0 || bus.active !== 1'b0 || bus.note_idx !== 3'd0) begin
            failures++;
            $display("FAIL async_reset: spk=%b act=%b note=%0d want 0 0 0",
                     bus.speaker, bus.active, bus.note_idx);
        end
        tick(2);
        rst_n = 1'b1;
        tick(2);
        checks++;
        if (bus.active !== 1'b0) begin
            failures++;
            $display("FAIL replay_early: active=%b want 0", bus.active);
        end
        tick(1);
        checks++;
        if (bus.active !== 1'b1 || bus.note_idx !== 3'd4 || bus.speaker !== 1'b0) begin
            failures++;
            $display("FAIL replay_start: act=%b note=%0d spk=%b want 1 4 0",
                     bus.active, bus.note_idx, bus.speaker);
        end
        wait_toggle(n);
        checks++;
        if (n !== 124) begin
            failures++;
            $display("FAIL replay_half: cycles=%0d want 124", n);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_single_key();
        test_note_change("c_to_e", 7'b0000101, 3'd2, 148);
        test_note_change("e_to_c", 7'b0000001, 3'd0, 186);
        test_multi_rise();
        test_mute_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
